// File: rtl/mt_stream_gen.sv
// Mersenne Twister generator (MT19937 / MT19937-64 by parameter) with a valid/ready output stream.
// First out_valid appears 2N+2 clock edges after reset release or after the seed-accepting edge.
module mt_stream_gen #(
  parameter int             W            = 32,
  parameter int             N            = 624,
  parameter int             M            = 397,
  parameter int             R            = 31,
  parameter logic [W-1:0]   A            = W'(32'h9908B0DF),
  parameter int             U            = 11,
  parameter logic [W-1:0]   D            = W'(32'hFFFFFFFF),
  parameter int             S            = 7,
  parameter logic [W-1:0]   B            = W'(32'h9D2C5680),
  parameter int             T            = 15,
  parameter logic [W-1:0]   C            = W'(32'hEFC60000),
  parameter int             L            = 18,
  parameter logic [W-1:0]   F            = W'(1812433253),
  parameter logic [W-1:0]   DEFAULT_SEED = W'(5489)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         seed_valid,
  input  logic [W-1:0] seed,
  output logic         seed_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {ST_INIT, ST_TWIST, ST_OUT} state_t;

  localparam int AW = $clog2(N);
  localparam int IW = $clog2(N + 1);
  localparam logic [IW-1:0] LAST_I = IW'(N - 1);
  localparam logic [IW-1:0] FULL_I = IW'(N);
  localparam logic [IW-1:0] WRAP_I = IW'(N - M);
  localparam logic [IW-1:0] M_I    = IW'(M);
  localparam logic [W-1:0]  LOWER  = (W'(1) << R) - W'(1);
  localparam logic [W-1:0]  UPPER  = ~LOWER;

  function automatic logic [W-1:0] temper(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = x;
    y = y ^ ((y >> U) & D);
    y = y ^ ((y << S) & B);
    y = y ^ ((y << T) & C);
    y = y ^ (y >> L);
    return y;
  endfunction

  state_t        state_q, state_d;
  logic [IW-1:0] index_q, index_d;
  logic          fill_q, fill_d;
  logic [W-1:0]  prev_q, prev_d;
  logic [W-1:0]  cur_q, cur_d;
  logic [W-1:0]  pending_seed;
  logic          out_valid_d, out_load;
  logic          we;
  logic [AW-1:0] wa, ra_a, ra_b;
  logic [W-1:0]  wd, rd_a, rd_b;
  logic [IW-1:0] next_i, mid_i;
  logic [W-1:0]  init_word, twist_word, x;
  logic          seed_accept, take, slot_free;

  // NOTE: the state array has no reset; INIT rewrites every word before anything reads it.
  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd_a = mem[ra_a];
  assign rd_b = mem[ra_b];

  assign seed_accept = seed_valid && seed_ready;
  assign take        = out_valid && out_ready;
  assign slot_free   = !out_valid || out_ready;
  assign busy        = (state_q == ST_INIT) || (state_q == ST_TWIST);

  assign next_i = (index_q == LAST_I) ? '0 : index_q + IW'(1);
  assign mid_i  = (index_q >= WRAP_I) ? index_q - WRAP_I : index_q + M_I;

  assign init_word = F * (prev_q ^ (prev_q >> (W - 2))) + W'(index_q);

  // Writes land before the next cycle's asynchronous reads, so the in-place twist
  // always sees words already updated earlier in the pass.
  assign x          = (cur_q & UPPER) | (rd_a & LOWER);
  assign twist_word = rd_b ^ (x >> 1) ^ (x[0] ? A : '0);

  // Read addresses depend on registered state only, keeping the datapath loop-free.
  always_comb begin
    ra_a = AW'(index_q);
    ra_b = AW'(mid_i);
    if (state_q == ST_TWIST) ra_a = fill_q ? '0 : AW'(next_i);
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    fill_d      = fill_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    out_valid_d = out_valid;
    out_load    = 1'b0;
    we          = 1'b0;
    wa          = AW'(index_q);
    wd          = '0;

    case (state_q)
      ST_INIT: begin
        we     = 1'b1;
        wd     = (index_q == '0) ? pending_seed : init_word;
        prev_d = wd;
        if (index_q == LAST_I) begin
          state_d = ST_TWIST;
          index_d = '0;
          fill_d  = 1'b1;
        end else begin
          index_d = index_q + IW'(1);
        end
      end
      ST_TWIST: begin
        cur_d = rd_a;
        if (fill_q) begin
          fill_d = 1'b0;
        end else begin
          we = 1'b1;
          wd = twist_word;
          if (index_q == LAST_I) begin
            state_d = ST_OUT;
            index_d = '0;
          end else begin
            index_d = index_q + IW'(1);
          end
        end
      end
      ST_OUT: begin
        if (slot_free && index_q != FULL_I) begin
          out_load    = 1'b1;
          out_valid_d = 1'b1;
          index_d     = index_q + IW'(1);
        end else if (take) begin
          out_valid_d = 1'b0;
          state_d     = ST_TWIST;
          index_d     = '0;
          fill_d      = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // A coincident transfer has already completed at this edge; the reseed wins otherwise.
    if (seed_accept) begin
      state_d     = ST_INIT;
      index_d     = '0;
      out_valid_d = 1'b0;
      out_load    = 1'b0;
      we          = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      index_q      <= '0;
      fill_q       <= 1'b0;
      prev_q       <= '0;
      cur_q        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      seed_ready   <= 1'b0;
      pending_seed <= DEFAULT_SEED;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      fill_q     <= fill_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      out_valid  <= out_valid_d;
      seed_ready <= 1'b1;
      if (out_load)    out_data     <= temper(rd_a);
      if (seed_accept) pending_seed <= seed;
    end
  end

endmodule
